// File: rtl/memory_stage.sv
// Pipeline memory stage: EX/MEM latch, data-cache access FSM with timeout, MEM/WB register.
// Optional MEM_FWD_EN macro enables the MEM-stage forwarding outputs (tied to 0 otherwise).
module memory_stage #(
  parameter int MAX_WAIT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        exen,
  input  logic        flush,
  input  logic [31:0] ALUOut_next,
  input  logic [31:0] dmemstore_next,
  input  logic [31:0] nPC_next,
  input  logic [31:0] lui_next,
  input  logic        dREN_next,
  input  logic        dWEN_next,
  input  logic        regWr_next,
  input  logic        halt_next,
  input  logic [2:0]  regSel_next,
  input  logic [4:0]  regDst_next,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic        mem_stall,
  output logic        wb_regWr,
  output logic [2:0]  wb_regSel,
  output logic [4:0]  wb_regDst,
  output logic [31:0] wb_wdat,
  output logic        wb_halt,
  output logic        mem_err,
  output logic        fwd_valid,
  output logic [4:0]  fwd_regDst,
  output logic [31:0] fwd_data
);
  typedef enum logic {IDLE, ACCESS} state_e;
  state_e state;

  logic [31:0] l_alu, l_store, l_npc, l_lui, ld_q;
  logic        l_dren, l_dwen, l_regwr, l_halt;
  logic [2:0]  l_regsel;
  logic [4:0]  l_regdst;
  logic [7:0]  wait_cnt;

  logic        in_access, timeout, load_en, new_memop;
  logic [31:0] rd_data, sel_data;

  assign in_access = (state == ACCESS);
  assign timeout   = in_access & (wait_cnt == 8'(MAX_WAIT - 1)) & ~dhit;
  assign mem_stall = in_access & ~dhit & ~timeout;
  // A latched or written-back halt freezes the latch so nothing behind it issues.
  assign load_en   = ~mem_stall & ~l_halt & ~wb_halt & (flush | exen);
  assign new_memop = ~flush & (dREN_next | dWEN_next);

  assign dmemREN   = in_access & l_dren;
  assign dmemWEN   = in_access & l_dwen;
  assign dmemaddr  = in_access ? l_alu   : 32'h0;
  assign dmemstore = in_access ? l_store : 32'h0;

  // Load data is live only in the dhit cycle; afterwards the captured copy is used.
  assign rd_data = (in_access & dhit) ? dmemload : ld_q;

  always_comb begin
    sel_data = l_alu;
    case (l_regsel)
      3'd1:    sel_data = rd_data;
      3'd2:    sel_data = l_npc;
      3'd3:    sel_data = l_lui;
      default: sel_data = l_alu;
    endcase
  end

`ifdef MEM_FWD_EN
  assign fwd_valid  = l_regwr & (l_regsel != 3'd1);
  assign fwd_regDst = l_regdst;
  assign fwd_data   = sel_data;
`else
  assign fwd_valid  = 1'b0;
  assign fwd_regDst = 5'd0;
  assign fwd_data   = 32'd0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      wait_cnt <= 8'd0;
      l_alu    <= 32'd0;
      l_store  <= 32'd0;
      l_npc    <= 32'd0;
      l_lui    <= 32'd0;
      l_dren   <= 1'b0;
      l_dwen   <= 1'b0;
      l_regwr  <= 1'b0;
      l_halt   <= 1'b0;
      l_regsel <= 3'd0;
      l_regdst <= 5'd0;
      ld_q     <= 32'd0;
    end else begin
      if (in_access & dhit) ld_q <= dmemload;
      if (load_en) begin
        l_alu    <= flush ? 32'd0 : ALUOut_next;
        l_store  <= flush ? 32'd0 : dmemstore_next;
        l_npc    <= flush ? 32'd0 : nPC_next;
        l_lui    <= flush ? 32'd0 : lui_next;
        l_dren   <= ~flush & dREN_next;
        l_dwen   <= ~flush & dWEN_next;
        l_regwr  <= ~flush & regWr_next;
        l_halt   <= ~flush & halt_next;
        l_regsel <= flush ? 3'd0 : regSel_next;
        l_regdst <= flush ? 5'd0 : regDst_next;
        state    <= new_memop ? ACCESS : IDLE;
        wait_cnt <= 8'd0;
      end else if (in_access) begin
        if (dhit | timeout) state <= IDLE;
        else                wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wb_regWr  <= 1'b0;
      wb_regSel <= 3'd0;
      wb_regDst <= 5'd0;
      wb_wdat   <= 32'd0;
      wb_halt   <= 1'b0;
      mem_err   <= 1'b0;
    end else begin
      if (timeout) mem_err <= 1'b1;
      if (mem_stall | timeout) begin
        wb_regWr  <= 1'b0;
        wb_regSel <= 3'd0;
        wb_regDst <= 5'd0;
        wb_wdat   <= 32'd0;
      end else begin
        wb_regWr  <= l_regwr;
        wb_regSel <= l_regsel;
        wb_regDst <= l_regdst;
        wb_wdat   <= sel_data;
        wb_halt   <= wb_halt | l_halt;
      end
    end
  end
endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 255, meaning the maximum number of ACCESS cycles without dhit before abort (legal range 1..255).
REQ-002 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port exen, input, 1, EX/MEM latch enable.
REQ-005 SHALL have port flush, input, 1, which loads a bubble into the EX/MEM latch.
REQ-006 SHALL have ports ALUOut_next, dmemstore_next, nPC_next, lui_next, inputs, 32 each, from execute.
REQ-007 SHALL have ports dREN_next, dWEN_next, regWr_next, halt_next, inputs, 1 each, from execute.
REQ-008 SHALL have ports regSel_next (input, 3) and regDst_next (input, 5), from execute.
REQ-009 SHALL have port dhit, input, 1, data-cache completion.
REQ-010 SHALL have port dmemload, input, 32, data-cache read data.
REQ-011 SHALL have ports dmemREN and dmemWEN (outputs, 1 each) and dmemaddr and dmemstore (outputs, 32 each), the cache request.
REQ-012 SHALL have port mem_stall, output, 1, which freezes upstream stages.
REQ-013 SHALL have ports wb_regWr (1), wb_regSel (3), wb_regDst (5), wb_wdat (32), wb_halt (1), all outputs, the MEM/WB register.
REQ-014 SHALL have port mem_err, output, 1, a sticky timeout flag.
REQ-015 SHALL have ports fwd_valid (1), fwd_regDst (5), fwd_data (32), all outputs, for forwarding (see Configuration).

Function
REQ-016 The EX/MEM latch SHALL load all *_next inputs on exen=1 and mem_stall=0.
REQ-017 When flush=1 and mem_stall=0, the EX/MEM latch SHALL load a bubble (dREN=dWEN=regWr=halt=0, other fields 0); flush SHALL win over exen.
REQ-018 flush and exen SHALL be ignored while mem_stall=1, so an in-flight access always completes.
REQ-019 The FSM SHALL have states IDLE and ACCESS; on an EX/MEM load with dREN_next|dWEN_next=1 the next state SHALL be ACCESS, otherwise IDLE.
REQ-020 In ACCESS: dmemREN=latched dREN, dmemWEN=latched dWEN, dmemaddr=latched ALUOut, dmemstore=latched dmemstore; in IDLE all four SHALL be 0.
REQ-021 mem_stall SHALL equal (state==ACCESS) & ~dhit & ~timeout, combinationally.
REQ-022 On ACCESS with dhit=1 the FSM SHALL return to IDLE, or stay in ACCESS if a new memory op is loaded in that same edge; the dhit cycle SHALL have stall=0.
REQ-023 A wait counter SHALL clear on ACCESS entry and increment per ACCESS cycle without dhit.
REQ-024 timeout SHALL be (counter==MAX_WAIT-1) & ~dhit; on timeout the access SHALL be abandoned, mem_err set, and the MEM/WB register SHALL load a bubble.
REQ-025 The MEM/WB register SHALL load on every edge: a bubble (wb_regWr=0, wb_halt=0) when mem_stall=1, else the latched fields.
REQ-026 wb_wdat SHALL be selected by regSel: 0 ALUOut, 1 dmemload (captured in the dhit cycle), 2 nPC, 3 lui, 4..7 ALUOut.
REQ-027 wb_halt SHALL be sticky once 1; after that, EX/MEM loads SHALL be blocked and no further cache requests issued.
REQ-028 dhit outside ACCESS SHALL be ignored.

Reset
REQ-029 RST=1 SHALL asynchronously force state=IDLE, counter=0, both latches to bubble, wb_*=0, mem_err=0, and all cache outputs and mem_stall to 0.
REQ-030 Reset mid-ACCESS SHALL drop the request in the same cycle, with no write-back.

Configuration
REQ-031 With macro MEM_FWD_EN defined: fwd_valid=latched regWr & regSel!=1, fwd_regDst=latched regDst, fwd_data=wb_wdat mux over the EX/MEM latch, all combinational.
REQ-032 Without MEM_FWD_EN, all fwd_* outputs SHALL be tied to 0 and the forwarding mux SHALL not exist.

Verification
REQ-033 Load: ALUOut=0x100, dREN=1, regSel=1, regDst=8, dhit after 3 cycles, dmemload=0xDEADBEEF -> mem_stall=1 for 3 cycles, dmemaddr=0x100, then next cycle wb_regWr=1, wb_regDst=8, wb_wdat=0xDEADBEEF.
REQ-034 Store: dWEN=1, dmemstore=0x55, dhit same cycle -> dmemWEN=1 one cycle, mem_stall=0, wb_regWr=0 for that op.
REQ-035 Timeout with MAX_WAIT=4 and dhit never asserted -> mem_stall=1 for 3 cycles, then mem_err=1 (sticky), bubble written back, FSM in IDLE.
REQ-036 flush with exen=1 during a stalled load -> load completes unaffected; flush with exen=1 while not stalled -> bubble latched, no request issued.
REQ-037 halt_next=1 followed by a load -> wb_halt=1 stays 1 and dmemREN is never asserted; RST pulse mid-ACCESS -> all outputs 0 immediately.
REQ-038 MEM_FWD_EN on: ALU op regDst=3, ALUOut=7 -> fwd_valid=1, fwd_data=7; MEM_FWD_EN off -> fwd_* =0.
